// File: rtl/stack_lifo.sv
// stack_lifo -- hardware LIFO for return addresses (CALL/RET) and PUSH/POP data.
//
// The stack pointer sp is an up/down entry counter: push counts up, pop counts
// down, clr loads 0. Push/pop are single-cycle and registered; popped data
// appears on out one edge after the pop, qualified by a one-cycle out_valid.
//
// Optional build macro: STACK_ERR_STICKY_EN
//   defined   : err latches on overflow/underflow and holds until clr or reset.
//   undefined : err is a one-cycle pulse on the edge following each
//               overflow/underflow.
//
// Parameters
//   WIDTH  data word width
//   DEPTH  number of entries (power of 2, >= 2)
//   SPW    pointer width, holds 0..DEPTH (derived)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   clr        synchronous flush (sp <= 0), wins over push/pop
//   push       push d_in this cycle
//   pop        pop top-of-stack this cycle
//   d_in       push data
//   out        registered pop data
//   out_valid  one-cycle pulse: out updated by a pop on this edge
//   sp         current entry count
//   full       sp == DEPTH
//   empty      sp == 0
//   err        overflow/underflow indication
module stack_lifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int SPW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [SPW-1:0]   sp,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [SPW-1:0]   sp_reg,        sp_next;
  logic [WIDTH-1:0] out_reg,       out_next;
  logic             out_valid_reg, out_valid_next;
  logic             err_reg,       err_next;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    top_idx;

  logic do_push, do_pop, do_repl, do_byp, ovf, udf;

  assign full  = (sp_reg == SPW'(DEPTH));
  assign empty = (sp_reg == '0);

  // When sp == DEPTH the low bits wrap to 0, so subtracting one still lands
  // on the last entry.
  assign top_idx = sp_reg[AW-1:0] - AW'(1);

  // Operation decode; clr masks all of these in the update logic below.
  assign do_push = push & ~pop & ~full;
  assign ovf     = push & ~pop &  full;
  assign do_pop  = pop & ~push & ~empty;
  assign udf     = pop & ~push &  empty;
  assign do_repl = push & pop & ~empty;  // replace top, old top goes out
  assign do_byp  = push & pop &  empty;  // nothing stored: forward d_in

  always_comb begin
    sp_next        = sp_reg;
    out_next       = out_reg;
    out_valid_next = 1'b0;
`ifdef STACK_ERR_STICKY_EN
    err_next       = err_reg;
`else
    err_next       = 1'b0;
`endif
    mem_we         = 1'b0;
    mem_waddr      = sp_reg[AW-1:0];

    if (clr) begin
      sp_next  = '0;
      err_next = 1'b0;
    end else begin
      if (do_push) begin
        mem_we  = 1'b1;
        sp_next = sp_reg + SPW'(1);
      end
      if (do_pop) begin
        out_next       = mem[top_idx];
        out_valid_next = 1'b1;
        sp_next        = sp_reg - SPW'(1);
      end
      if (do_repl) begin
        // Read of the old top and write of the new one share the edge.
        out_next       = mem[top_idx];
        out_valid_next = 1'b1;
        mem_we         = 1'b1;
        mem_waddr      = top_idx;
      end
      if (do_byp) begin
        out_next       = d_in;
        out_valid_next = 1'b1;
      end
      if (ovf || udf) begin
        err_next = 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= d_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_reg        <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      sp_reg        <= sp_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
      err_reg       <= err_next;
    end
  end

  assign sp        = sp_reg;
  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_stack_lifo.sv
// Testbench for stack_lifo (DEPTH=4, WIDTH=16). Compares the DUT against a
// queue-based stack model after every clock edge; works in either macro build.
module tb_stack_lifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int SPW   = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             clr;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic [SPW-1:0]   sp;
  logic             full;
  logic             empty;
  logic             err;

  stack_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .push      (push),
    .pop       (pop),
    .d_in      (d_in),
    .out       (out),
    .out_valid (out_valid),
    .sp        (sp),
    .full      (full),
    .empty     (empty),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue whose back is the top of stack.
  logic [WIDTH-1:0] q [$];
  logic [WIDTH-1:0] exp_out;
  logic             exp_ov;
  logic             exp_err;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".sp"},        32'(sp),        32'(q.size()));
    chk({tag, ".full"},      32'(full),      32'(q.size() == DEPTH));
    chk({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
    chk({tag, ".out"},       32'(out),       32'(exp_out));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
    chk({tag, ".err"},       32'(err),       32'(exp_err));
  endtask

  task automatic model_step(input logic pu, input logic po, input logic cl,
                            input logic [WIDTH-1:0] d);
    logic ev;
    ev     = 1'b0;
    exp_ov = 1'b0;
    if (cl) begin
      q.delete();
    end else if (pu && po) begin
      exp_ov = 1'b1;
      if (q.size() == 0) begin
        exp_out = d;
      end else begin
        exp_out = q[q.size()-1];
        q[q.size()-1] = d;
      end
    end else if (pu) begin
      if (q.size() < DEPTH) q.push_back(d);
      else ev = 1'b1;
    end else if (po) begin
      if (q.size() > 0) begin
        exp_out = q.pop_back();
        exp_ov  = 1'b1;
      end else begin
        ev = 1'b1;
      end
    end
`ifdef STACK_ERR_STICKY_EN
    if (cl) exp_err = 1'b0;
    else if (ev) exp_err = 1'b1;
`else
    exp_err = ev;
`endif
  endtask

  // One clock: drive, edge, update model, check #1 after the edge.
  task automatic cycle(input string tag, input logic pu, input logic po,
                       input logic cl, input logic [WIDTH-1:0] d);
    push = pu; pop = po; clr = cl; d_in = d;
    @(posedge clk);
    model_step(pu, po, cl, d);
    #1;
    chk_all(tag);
    $display("%-10s push=%0b pop=%0b clr=%0b d_in=%h -> out=%h ov=%0b sp=%0d err=%0b",
             tag, pu, po, cl, d, out, out_valid, sp, err);
  endtask

  // Called 1 time unit after a posedge: assert reset mid-cycle, check that it
  // takes effect before the next edge, hold through one edge, then release.
  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    exp_out = '0; exp_ov = 1'b0; exp_err = 1'b0;
    chk_all({tag, ".async"});
    @(posedge clk);
    #1;
    chk_all({tag, ".held"});
    rst = 1'b1;
    $display("%-10s reset pulse -> sp=%0d empty=%0b out=%h", tag, sp, empty, out);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; d_in = '0;
    q.delete();
    exp_out = '0; exp_ov = 1'b0; exp_err = 1'b0;

    // 1: power-on reset state
    #3;
    chk_all("por");
    @(posedge clk); #1;
    rst = 1'b1;

    // 2: fill and drain
    cycle("fill", 1, 0, 0, 16'h1111);
    cycle("fill", 1, 0, 0, 16'h2222);
    cycle("fill", 1, 0, 0, 16'h3333);
    cycle("fill", 1, 0, 0, 16'h4444);
    chk("fill.sp4", 32'(sp), 32'd4);
    chk("fill.full", 32'(full), 32'd1);
    cycle("drain", 0, 1, 0, 16'h0000);
    chk("drain.o1", 32'(out), 32'h4444);
    cycle("drain", 0, 1, 0, 16'h0000);
    cycle("drain", 0, 1, 0, 16'h0000);
    cycle("drain", 0, 1, 0, 16'h0000);
    chk("drain.o4", 32'(out), 32'h1111);
    chk("drain.empty", 32'(empty), 32'd1);

    // 3: overflow
    cycle("refill", 1, 0, 0, 16'h1111);
    cycle("refill", 1, 0, 0, 16'h2222);
    cycle("refill", 1, 0, 0, 16'h3333);
    cycle("refill", 1, 0, 0, 16'h4444);
    cycle("ovf", 1, 0, 0, 16'h5555);
    chk("ovf.err", 32'(err), 32'd1);
    chk("ovf.sp", 32'(sp), 32'd4);
    cycle("ovf_idle", 0, 0, 0, 16'h0000);
    cycle("ovf_pop", 0, 1, 0, 16'h0000);
    chk("ovf.pop", 32'(out), 32'h4444);

    // 4: underflow
    cycle("drain2", 0, 1, 0, 16'h0000);
    cycle("drain2", 0, 1, 0, 16'h0000);
    cycle("drain2", 0, 1, 0, 16'h0000);
    cycle("udf", 0, 1, 0, 16'h0000);
    chk("udf.hold", 32'(out), 32'h1111);
    chk("udf.err", 32'(err), 32'd1);
    chk("udf.ov", 32'(out_valid), 32'd0);

    // 5: simultaneous push & pop
    cycle("clr", 0, 0, 1, 16'h0000);
    cycle("sim", 1, 0, 0, 16'hAAAA);
    cycle("sim", 1, 0, 0, 16'hBBBB);
    cycle("repl", 1, 1, 0, 16'hCCCC);
    chk("repl.out", 32'(out), 32'hBBBB);
    cycle("repl_pop", 0, 1, 0, 16'h0000);
    chk("repl.new", 32'(out), 32'hCCCC);
    cycle("sim", 0, 1, 0, 16'h0000);
    cycle("byp", 1, 1, 0, 16'hAAAA);
    chk("byp.out", 32'(out), 32'hAAAA);
    chk("byp.sp", 32'(sp), 32'd0);

    // 6: clr and reset mid-operation
    cycle("pre_clr", 1, 0, 0, 16'h0101);
    cycle("pre_clr", 1, 0, 0, 16'h0202);
    cycle("pre_clr", 1, 0, 0, 16'h0303);
    cycle("pre_clr", 1, 0, 0, 16'h0404);
    cycle("ovf2", 1, 0, 0, 16'h0505);
    cycle("clr_push", 1, 0, 1, 16'h0606);
    chk("clr.sp", 32'(sp), 32'd0);
    chk("clr.err", 32'(err), 32'd0);
    cycle("clr_udf", 0, 1, 0, 16'h0000);
    cycle("pre_rst", 1, 0, 0, 16'h0707);
    cycle("pre_rst", 1, 0, 0, 16'h0808);
    push = 1'b1; pop = 1'b0; clr = 1'b0; d_in = 16'h0909;
    mid_reset("rst_push");
    cycle("post_rst", 1, 0, 0, 16'h1234);
    cycle("post_rst", 0, 1, 0, 16'h0000);
    chk("post_rst.out", 32'(out), 32'h1234);

    // Random traffic against the model, with an occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      logic pu, po, cl;
      pu = ($urandom_range(0, 99) < 50);
      po = ($urandom_range(0, 99) < 45);
      cl = ($urandom_range(0, 39) == 0);
      cycle("rand", pu, po, cl, 16'($urandom));
      if (i == 200) mid_reset("rand_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
